// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, threshold flags, a read-data
// strobe and sticky overflow/underflow flags. All state changes on the rising clk edge.
module sync_fifo_param #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 3,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   input  logic              clr_err,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic [ADDR_W:0]   level,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_L  = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_L = (ADDR_W+1)'(AEMPTY_TH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic              wr_acc;
   logic              rd_acc;

   // Handshake: wr_en/rd_en are requests that are never back-pressured; a
   // request is taken only when wr_acc/rd_acc is high, and a taken read shows
   // up one edge later as dout with a single-cycle dout_valid strobe.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_en);

   assign empty        = (level == '0);
   assign full         = (level == DEPTH_L);
   assign almost_empty = (level <= AEMPTY_L);
   assign almost_full  = (level >= AFULL_L);

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc)
         mem[wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr       <= '0;
         rptr       <= '0;
         level      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_acc)
            wptr <= wptr + 1'b1;
         if (rd_acc) begin
            dout       <= mem[rptr];
            rptr       <= rptr + 1'b1;
            dout_valid <= 1'b1;
         end else begin
            dout_valid <= 1'b0;
         end
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         // A new error event in the same cycle as clr_err keeps the flag set.
         if (wr_en && full && !rd_en)
            overflow <= 1'b1;
         else if (clr_err)
            overflow <= 1'b0;
         if (rd_en && empty)
            underflow <= 1'b1;
         else if (clr_err)
            underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param: a queue-based reference
// model predicts occupancy, flags and read data; a monitor compares every cycle.
module tb_sync_fifo_param;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic              rd_en = 1'b0;
   logic              clr_err = 1'b0;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic [ADDR_W:0]   level;
   logic              empty, full, almost_empty, almost_full, overflow, underflow;

   sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid), .level(level),
      .empty(empty), .full(full), .almost_empty(almost_empty),
      .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a plain queue plus the sticky flags.
   logic [DATA_W-1:0] model_q[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_dout = '0;
   bit                exp_dv = 0;
   bit                exp_ov = 0;
   bit                exp_un = 0;
   bit                mon_en = 0;
   int                vectors = 0;
   int                miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit w, input logic [DATA_W-1:0] d, input bit r, input bit c);
      bit is_full, is_empty;
      @(negedge clk);
      reset = 1'b0; wr_en = w; din = d; rd_en = r; clr_err = c;
      is_full  = (model_q.size() == DEPTH);
      is_empty = (model_q.size() == 0);
      if (w && is_full && !r) exp_ov = 1;
      else if (c)             exp_ov = 0;
      if (r && is_empty)      exp_un = 1;
      else if (c)             exp_un = 0;
      exp_dv = 0;
      if (r && !is_empty) begin
         exp_dout = model_q.pop_front();
         exp_q.push_back(exp_dout);
         exp_dv = 1;
      end
      if (w && (!is_full || r))
         model_q.push_back(d);
   endtask

   task automatic do_reset(input bit w, input bit r);
      @(negedge clk);
      reset = 1'b1; wr_en = w; rd_en = r; din = $urandom; clr_err = 1'b0;
      model_q.delete();
      exp_dout = '0; exp_dv = 0; exp_ov = 0; exp_un = 0;
      mon_en = 1;
   endtask

   // Monitor: checks the DUT one step after each driven edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            chk("level", level, model_q.size());
            chk("empty", empty, model_q.size() == 0);
            chk("full", full, model_q.size() == DEPTH);
            chk("almost_empty", almost_empty, model_q.size() <= 1);
            chk("almost_full", almost_full, model_q.size() >= 6);
            chk("overflow", overflow, exp_ov);
            chk("underflow", underflow, exp_un);
            chk("dout_valid", dout_valid, exp_dv);
            chk("dout_hold", dout, exp_dout);
            if (dout_valid) begin
               if (exp_q.size() == 0)
                  chk("unexpected_read", 1, 0);
               else
                  chk("read_data", dout, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      do_reset(0, 0);
      do_reset(1, 1);
      // Fill with 0x11..0x88 then overflow attempt and clear.
      for (int i = 1; i <= 8; i++) step(1, 32'h11 * i, 0, 0);
      step(1, 32'hDEAD, 0, 0);
      step(0, '0, 0, 1);
      // Full-rate simultaneous read/write while full.
      for (int i = 0; i < 20; i++) step(1, 32'h100 + i, 1, 0);
      for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
      // Empty with read and write together.
      step(1, 32'hA5, 1, 0);
      step(0, '0, 1, 1);
      // Reset mid-traffic at level 5, then prove stale data is gone.
      for (int i = 0; i < 5; i++) step(1, 32'hBEEF0 + i, 0, 0);
      do_reset(1, 1);
      step(1, 32'h1234, 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 1, 0);
      // Threshold sweep up and down.
      for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0);
      for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
      step(0, '0, 0, 1);
      // Randomised traffic with occasional clears and resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0)
            do_reset($urandom_range(0, 1), $urandom_range(0, 1));
         else
            step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 9) == 0);
      end
      step(0, '0, 0, 0);
      step(0, '0, 0, 0);
      @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO and the next generation of the team's 32-bit, 8-entry synchronous FIFO. It generalises data width and depth, holds all 2^ADDR_W entries, and gives a true simultaneous read/write when full. It adds almost-full/almost-empty thresholds, an occupancy output, a read-data-valid strobe and sticky overflow/underflow error flags. It sits between a producer and consumer in the same clock domain, for example a command or data buffer ahead of a slower datapath stage.

## Interface
- DATA_W, 32, data width in bits (>=1)
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W entries (>=1)
- AFULL_TH, 6, almost_full asserts when level >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 1, almost_empty asserts when level <= AEMPTY_TH (0..DEPTH-1)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request
- clr_err  in  1  clears overflow/underflow (synchronous, one cycle)
- dout  out  DATA_W  registered read data
- dout_valid  out  1  one-cycle strobe: dout updated this cycle
- level  out  ADDR_W+1  current occupancy, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- almost_empty  out  1  level <= AEMPTY_TH
- almost_full  out  1  level >= AFULL_TH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was dropped

## Operation
- Storage: DEPTH x DATA_W array. wptr and rptr are ADDR_W bits and wrap naturally from DEPTH-1 to 0. level is an ADDR_W+1-bit registered counter.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_en). When full, a simultaneous read frees the slot, so both are accepted.
- Write accepted: mem[wptr] <= din; wptr <= wptr+1.
- Read accepted: dout <= mem[rptr]; rptr <= rptr+1; dout_valid <= 1. Otherwise dout holds and dout_valid <= 0.
- level update:
  - wr_acc only: +1
  - rd_acc only: -1
  - both or neither: unchanged
- Empty with rd_en and wr_en together: the write is accepted, the read is rejected, underflow sets, and level goes to 1.
- Flags are combinational decodes of the registered level, so they have no glitches between edges.
- Error flags:
  - overflow sets on wr_en && full && !rd_en.
  - underflow sets on rd_en && empty.
  - Both are sticky until reset or clr_err.
  - If clr_err coincides with a new error event, the flag stays set (set wins).
- Rejected operations change no pointer, memory word or level.
- Memory contents are not reset. Only pointers, level, dout, dout_valid and the error flags are.

## Timing
- Reset (synchronous, dominates all inputs) gives:
  - dout = 0, dout_valid = 0, level = 0, empty = 1, full = 0
  - almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0
  - wptr = rptr = 0
- Reset asserted mid-traffic discards all contents at that edge. Requests in the reset cycle are ignored.
- Write-to-read latency: a word written at edge N can be read by an rd_en sampled at edge N+1. The data appears on dout, with dout_valid high, after edge N+1.
- Read latency: 1 cycle from the rd_en sample edge to dout/dout_valid.
- Flag/level latency: level, empty, full, almost_* and the error flags reflect the operation one edge after it is sampled.
- No combinational path from din, wr_en or rd_en to any output.
- Back-to-back reads and writes at full rate (one per cycle each) are supported indefinitely with no bubbles.

## Test plan
All scenarios use DATA_W=32, ADDR_W=3, AFULL_TH=6, AEMPTY_TH=1.

- Reset, then write 0x11..0x88 (8 words), then 8 reads:
  - level counts 1..8; full=1 after the 8th write; almost_full=1 from level 6.
  - dout is 0x11..0x88 in order, each with dout_valid; empty=1 at the end; no error flags.
- Full FIFO, wr_en=1, rd_en=0 with din=0xDEAD:
  - overflow=1, level stays 8, 0xDEAD is never read.
  - clr_err clears overflow the next cycle.
- Full FIFO, wr_en=rd_en=1 for 20 cycles with an incrementing pattern:
  - level stays 8, full stays 1, no overflow.
  - Output is the original 8 words followed by the pattern in order; pointers wrap correctly.
- Empty FIFO, rd_en=wr_en=1 with din=0xA5:
  - underflow=1, dout_valid=0, level=1.
  - The next read returns 0xA5.
- Level at 5, then reset for one cycle while wr_en=rd_en=1:
  - All outputs return to reset values.
  - A subsequent write/read of 0x1234 returns 0x1234 (stale data is never read).
- Threshold sweep, level 0 to 8 and back:
  - almost_empty=1 exactly at levels 0..1.
  - almost_full=1 exactly at levels 6..8.
